// File: rtl/watch_time_cnt.sv
// watch_time_cnt: 24 h packed-BCD time-of-day counter advanced by en_1hz; registered outputs, visible after the sampling edge.
// Defining WATCH_ALARM_EN adds the alarm_* inputs and alarm_ring output with a 60-strobe ring timer.
module watch_time_cnt #(
   parameter logic [7:0] INIT_HOUR = 8'h00,
   parameter logic [7:0] INIT_MIN  = 8'h00,
   parameter logic [7:0] INIT_SEC  = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_1hz,
   input  logic       set_mode,
   input  logic       inc_min,
   input  logic       inc_hour,
   input  logic       clr_sec,
   output logic [7:0] sec_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] hour_bcd,
`ifdef WATCH_ALARM_EN
   input  logic [7:0] alarm_hour_bcd,
   input  logic [7:0] alarm_min_bcd,
   input  logic       alarm_arm,
   output logic       alarm_ring,
`endif
   output logic       tick_min,
   output logic       tick_hour,
   output logic       tick_day
);

   // Result is {wrap, next}; corrupted digits reload to 00 without a carry.
   function automatic logic [8:0] inc_sexa(input logic [7:0] v);
      logic [8:0] r;
      if (v[3:0] > 4'd9 || v[7:4] > 4'd5) begin
         r = 9'h000;
      end else if (v[3:0] == 4'd9) begin
         if (v[7:4] == 4'd5) r = {1'b1, 8'h00};
         else                r = {1'b0, v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {1'b0, v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   function automatic logic [8:0] inc_hour24(input logic [7:0] v);
      logic [8:0] r;
      if (v[3:0] > 4'd9 || v[7:4] > 4'd2 || (v[7:4] == 4'd2 && v[3:0] > 4'd3)) begin
         r = 9'h000;
      end else if (v == 8'h23) begin
         r = {1'b1, 8'h00};
      end else if (v[3:0] == 4'd9) begin
         r = {1'b0, v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {1'b0, v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   logic [7:0] sec_q, sec_d;
   logic [7:0] min_q, min_d;
   logic [7:0] hour_q, hour_d;
   logic       tick_min_q, tick_min_d;
   logic       tick_hour_q, tick_hour_d;
   logic       tick_day_q, tick_day_d;

   logic [8:0] sec_inc, min_inc, hour_inc;
   logic       sec_adv, sec_wrap, min_adv, min_wrap, hour_adv;

   always_comb begin
      sec_inc  = inc_sexa(sec_q);
      min_inc  = inc_sexa(min_q);
      hour_inc = inc_hour24(hour_q);

      // clr_sec wins over the strobe, so a cleared second never carries.
      sec_adv  = ~set_mode & en_1hz & ~clr_sec;
      sec_wrap = sec_adv & sec_inc[8];
      min_adv  = sec_wrap | (set_mode & inc_min);
      min_wrap = sec_wrap & min_inc[8];
      hour_adv = min_wrap | (set_mode & inc_hour);

      sec_d = sec_q;
      if (clr_sec)      sec_d = 8'h00;
      else if (sec_adv) sec_d = sec_inc[7:0];
      min_d  = min_adv  ? min_inc[7:0]  : min_q;
      hour_d = hour_adv ? hour_inc[7:0] : hour_q;

      tick_min_d  = sec_wrap;
      tick_hour_d = min_wrap;
      tick_day_d  = min_wrap & hour_inc[8];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sec_q       <= INIT_SEC;
         min_q       <= INIT_MIN;
         hour_q      <= INIT_HOUR;
         tick_min_q  <= 1'b0;
         tick_hour_q <= 1'b0;
         tick_day_q  <= 1'b0;
      end else begin
         sec_q       <= sec_d;
         min_q       <= min_d;
         hour_q      <= hour_d;
         tick_min_q  <= tick_min_d;
         tick_hour_q <= tick_hour_d;
         tick_day_q  <= tick_day_d;
      end
   end

   assign sec_bcd   = sec_q;
   assign min_bcd   = min_q;
   assign hour_bcd  = hour_q;
   assign tick_min  = tick_min_q;
   assign tick_hour = tick_hour_q;
   assign tick_day  = tick_day_q;

`ifdef WATCH_ALARM_EN
   logic       match_q, match_d;
   logic       ring_q, ring_d;
   logic [5:0] ring_cnt_q, ring_cnt_d;

   always_comb begin
      // Only a run-mode advance can hit the alarm time; set-mode edits never match.
      match_d = alarm_arm & sec_adv & (sec_d == 8'h00) &
                (min_d == alarm_min_bcd) & (hour_d == alarm_hour_bcd);
      ring_d     = ring_q;
      ring_cnt_d = ring_cnt_q;
      if (!alarm_arm) begin
         ring_d     = 1'b0;
         ring_cnt_d = 6'd0;
      end else if (match_q) begin
         ring_d     = 1'b1;
         ring_cnt_d = 6'd0;
      end else if (ring_q && en_1hz) begin
         if (ring_cnt_q == 6'd59) begin
            ring_d     = 1'b0;
            ring_cnt_d = 6'd0;
         end else begin
            ring_cnt_d = ring_cnt_q + 6'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         match_q    <= 1'b0;
         ring_q     <= 1'b0;
         ring_cnt_q <= 6'd0;
      end else begin
         match_q    <= match_d;
         ring_q     <= ring_d;
         ring_cnt_q <= ring_cnt_d;
      end
   end

   assign alarm_ring = ring_q;
`endif

endmodule

// File: tb/tb_watch_time_cnt.sv
// Directed bench for watch_time_cnt: one instance at default INIT, one at INIT 23:59:59, shared stimulus.
module tb_watch_time_cnt;

   logic clk = 1'b0;
   logic rst;
   logic en_1hz, set_mode, inc_min, inc_hour, clr_sec;
   logic [7:0] a_sec, a_min, a_hour, b_sec, b_min, b_hour;
   logic a_tmin, a_thour, a_tday, b_tmin, b_thour, b_tday;
   logic [2:0] a_t, b_t;
   int checks = 0;
   int errors = 0;
   logic any_tick;

`ifdef WATCH_ALARM_EN
   logic [7:0] alarm_hour_bcd, alarm_min_bcd;
   logic       alarm_arm;
   logic       a_ring, b_ring;
`endif

   always #5 clk = ~clk;

   assign a_t = {a_tday, a_thour, a_tmin};
   assign b_t = {b_tday, b_thour, b_tmin};

   watch_time_cnt u_a (
      .clk(clk), .rst(rst), .en_1hz(en_1hz), .set_mode(set_mode),
      .inc_min(inc_min), .inc_hour(inc_hour), .clr_sec(clr_sec),
      .sec_bcd(a_sec), .min_bcd(a_min), .hour_bcd(a_hour),
`ifdef WATCH_ALARM_EN
      .alarm_hour_bcd(alarm_hour_bcd), .alarm_min_bcd(alarm_min_bcd),
      .alarm_arm(alarm_arm), .alarm_ring(a_ring),
`endif
      .tick_min(a_tmin), .tick_hour(a_thour), .tick_day(a_tday)
   );

   watch_time_cnt #(.INIT_HOUR(8'h23), .INIT_MIN(8'h59), .INIT_SEC(8'h59)) u_b (
      .clk(clk), .rst(rst), .en_1hz(en_1hz), .set_mode(set_mode),
      .inc_min(inc_min), .inc_hour(inc_hour), .clr_sec(clr_sec),
      .sec_bcd(b_sec), .min_bcd(b_min), .hour_bcd(b_hour),
`ifdef WATCH_ALARM_EN
      .alarm_hour_bcd(alarm_hour_bcd), .alarm_min_bcd(alarm_min_bcd),
      .alarm_arm(alarm_arm), .alarm_ring(b_ring),
`endif
      .tick_min(b_tmin), .tick_hour(b_thour), .tick_day(b_tday)
   );

   typedef struct packed {
      logic       sm, en, im, ih, cs;
      logic [7:0] a_h, a_m, a_s;
      logic [2:0] a_t;
      logic [7:0] b_h, b_m, b_s;
      logic [2:0] b_t;
   } vec_t;

   vec_t tbl [0:12];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic sm, input logic en, input logic im, input logic ih, input logic cs);
      @(negedge clk);
      set_mode = sm; en_1hz = en; inc_min = im; inc_hour = ih; clr_sec = cs;
      @(posedge clk);
      #1;
      en_1hz = 1'b0; inc_min = 1'b0; inc_hour = 1'b0; clr_sec = 1'b0;
      any_tick = any_tick | (|a_t);
   endtask

   task automatic run(input int n, input logic sm, input logic en, input logic im, input logic ih, input logic cs);
      for (int i = 0; i < n; i++) step(sm, en, im, ih, cs);
   endtask

   initial begin
      //             sm    en    im    ih    cs    a_h    a_m    a_s    a_t     b_h    b_m    b_s    b_t
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 3'b000, 8'h00, 8'h00, 8'h00, 3'b111};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h02, 3'b000, 8'h00, 8'h00, 8'h01, 3'b000};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03, 3'b000, 8'h00, 8'h00, 8'h02, 3'b000};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03, 3'b000, 8'h00, 8'h00, 8'h02, 3'b000};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 8'h03, 3'b000, 8'h00, 8'h01, 8'h02, 3'b000};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 8'h03, 3'b000, 8'h01, 8'h01, 8'h02, 3'b000};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02, 8'h02, 8'h03, 3'b000, 8'h02, 8'h02, 8'h02, 3'b000};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 8'h02, 8'h00, 3'b000, 8'h02, 8'h02, 8'h00, 3'b000};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02, 8'h02, 8'h00, 3'b000, 8'h02, 8'h02, 8'h00, 3'b000};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 8'h02, 8'h00, 3'b000, 8'h02, 8'h02, 8'h00, 3'b000};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h02, 8'h01, 3'b000, 8'h02, 8'h02, 8'h01, 3'b000};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h02, 8'h01, 3'b000, 8'h02, 8'h02, 8'h01, 3'b000};

      rst = 1'b0; en_1hz = 1'b0; set_mode = 1'b0; inc_min = 1'b0; inc_hour = 1'b0; clr_sec = 1'b0;
      any_tick = 1'b0;
`ifdef WATCH_ALARM_EN
      alarm_hour_bcd = 8'h07; alarm_min_bcd = 8'h30; alarm_arm = 1'b0;
`endif
      #12;
      chk("rst a_sec", a_sec, 8'h00);
      chk("rst a_min", a_min, 8'h00);
      chk("rst a_hour", a_hour, 8'h00);
      chk("rst b_sec", b_sec, 8'h59);
      chk("rst b_min", b_min, 8'h59);
      chk("rst b_hour", b_hour, 8'h23);
      chk("rst a_ticks", {5'd0, a_t}, 8'h00);
      chk("rst b_ticks", {5'd0, b_t}, 8'h00);
      @(negedge clk) rst = 1'b1;

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].sm, tbl[i].en, tbl[i].im, tbl[i].ih, tbl[i].cs);
         chk($sformatf("v%0d a_hour", i), a_hour, tbl[i].a_h);
         chk($sformatf("v%0d a_min", i), a_min, tbl[i].a_m);
         chk($sformatf("v%0d a_sec", i), a_sec, tbl[i].a_s);
         chk($sformatf("v%0d a_ticks", i), {5'd0, a_t}, {5'd0, tbl[i].a_t});
         chk($sformatf("v%0d b_hour", i), b_hour, tbl[i].b_h);
         chk($sformatf("v%0d b_min", i), b_min, tbl[i].b_m);
         chk($sformatf("v%0d b_sec", i), b_sec, tbl[i].b_s);
         chk($sformatf("v%0d b_ticks", i), {5'd0, b_t}, {5'd0, tbl[i].b_t});
      end

      // Seconds wrap carrying into minutes: 02:02:59 -> 02:03:00.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run(59, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("s59 sec", a_sec, 8'h59);
      chk("s59 min", a_min, 8'h02);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("mwrap sec", a_sec, 8'h00);
      chk("mwrap min", a_min, 8'h03);
      chk("mwrap ticks", {5'd0, a_t}, 8'h01);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mwrap ticks gone", {5'd0, a_t}, 8'h00);

      // Minute wrap carrying into hours: 02:59:59 -> 03:00:00.
      run(56, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("set min59", a_min, 8'h59);
      chk("set hour kept", a_hour, 8'h02);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run(59, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("hwrap hour", a_hour, 8'h03);
      chk("hwrap min", a_min, 8'h00);
      chk("hwrap sec", a_sec, 8'h00);
      chk("hwrap ticks", {5'd0, a_t}, 8'h03);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hwrap ticks gone", {5'd0, a_t}, 8'h00);

      // Set-mode adjustments from 10:59:30 never tick nor move seconds.
      run(30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      any_tick = 1'b0;
      run(7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      run(59, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("adj hour10", a_hour, 8'h10);
      chk("adj min59", a_min, 8'h59);
      chk("adj sec30", a_sec, 8'h30);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("adj min00", a_min, 8'h00);
      chk("adj no carry", a_hour, 8'h10);
      run(13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("adj hour23", a_hour, 8'h23);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("adj hour00", a_hour, 8'h00);
      run(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("frozen sec", a_sec, 8'h30);
      chk("adj no ticks", {7'd0, any_tick}, 8'h00);

      // Asynchronous reset mid-count, checked between clock edges.
      run(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("pre-rst sec", a_sec, 8'h32);
      #2 rst = 1'b0;
      #1;
      chk("arst a_sec", a_sec, 8'h00);
      chk("arst a_hour", a_hour, 8'h00);
      chk("arst b_sec", b_sec, 8'h59);
      chk("arst b_hour", b_hour, 8'h23);
      @(negedge clk) rst = 1'b1;

`ifdef WATCH_ALARM_EN
      alarm_arm = 1'b1;
      run(7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      run(29, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      run(59, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("al 07:29:59 sec", a_sec, 8'h59);
      chk("al 07:29:59 min", a_min, 8'h29);
      chk("al quiet", {7'd0, a_ring}, 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("al hit min", a_min, 8'h30);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("al ring on", {7'd0, a_ring}, 8'h01);
      run(59, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("al ring 59", {7'd0, a_ring}, 8'h01);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("al ring 60 off", {7'd0, a_ring}, 8'h00);

      run(24, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      run(58, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("al set no ring", {7'd0, a_ring}, 8'h00);
      chk("al reset min", a_min, 8'h29);
      run(59, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("al2 ring on", {7'd0, a_ring}, 8'h01);
      run(5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("al2 ring 5s", {7'd0, a_ring}, 8'h01);
      @(negedge clk) alarm_arm = 1'b0;
      @(posedge clk);
      #1;
      chk("al2 disarm off", {7'd0, a_ring}, 8'h00);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/watch_time_cnt.md
Name: watch_time_cnt

Overview:
Time-of-day counter that sits directly downstream of the 1 Hz enable generator. It consumes the single-cycle en_1hz strobe and keeps seconds, minutes and hours (24 h) as packed BCD for the 7-segment display driver. It provides set-mode controls for adjusting the time from pushbuttons and one-cycle rollover ticks for other blocks.

Parameters:
INIT_HOUR, 8'h00, BCD hour loaded on reset (must be 00..23).
INIT_MIN, 8'h00, BCD minute loaded on reset (must be 00..59).
INIT_SEC, 8'h00, BCD second loaded on reset (must be 00..59).

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous, active-low reset
en_1hz  in  1  one-clk-wide strobe, once per second
set_mode  in  1  level; 1 = time adjust, seconds frozen
inc_min  in  1  one-clk pulse (debounced upstream); minute +1 in set mode
inc_hour  in  1  one-clk pulse; hour +1 in set mode
clr_sec  in  1  one-clk pulse; seconds := 00 in any mode
sec_bcd  out  8  {tens[7:4], ones[3:0]}, 00..59
min_bcd  out  8  00..59
hour_bcd  out  8  00..23
tick_min  out  1  one-clk pulse on 59->00 seconds rollover
tick_hour  out  1  one-clk pulse on 59:59 -> 00:00 min:sec rollover
tick_day  out  1  one-clk pulse on 23:59:59 -> 00:00:00

Behaviour:
- Reset (rst=0, async): sec/min/hour := INIT_SEC/INIT_MIN/INIT_HOUR. All ticks := 0. This applies mid-operation too; no partial carry survives.
- All outputs are registered. An event sampled at edge N is visible after edge N. Ticks are high for exactly the cycle in which the wrapped value is first visible.
- Counting is done directly in BCD, with no binary-to-BCD conversion:
  - ones 9 -> 0 with tens +1.
  - sec/min: 59 -> 00 plus carry.
  - hour: 23 -> 00 (ones wraps at 3 when tens = 2) plus tick_day.
- Run mode (set_mode=0), on en_1hz=1: sec +1.
  - Carry into min only on the 59 -> 00 wrap; min carry into hour likewise.
  - inc_min and inc_hour are ignored.
- Set mode (set_mode=1): en_1hz is ignored (time frozen).
  - inc_min: min +1, 59 -> 00, no carry into hour, no ticks.
  - inc_hour: hour +1, 23 -> 00, no tick_day.
  - inc_min and inc_hour in the same cycle are both applied independently.
- clr_sec has priority over en_1hz in the same cycle: sec := 00, no carry, no tick_min. It is valid in both modes.
- A set_mode change takes effect on the next edge. An en_1hz coinciding with the set_mode 0->1 edge is ignored.
- Illegal BCD states are unreachable. If forced (e.g. by a SEU), any digit >9, tens >5 (sec/min) or hour >23 is reloaded to 00 on the next advance of that field.

Optional Feature:
Macro WATCH_ALARM_EN.
- Defined: adds the following ports:
  - inputs alarm_hour_bcd[7:0], alarm_min_bcd[7:0], alarm_arm (level);
  - output alarm_ring (reset 0).
- alarm_ring sets one cycle after a run-mode advance yields hour:min equal to the alarm time with sec = 00, while alarm_arm = 1.
- A 6-bit ring counter then counts en_1hz strobes. alarm_ring clears after 60 strobes or immediately (next edge) when alarm_arm = 0.
- Adjusting time in set mode never triggers the alarm.
- Undefined: these ports and the alarm logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset with defaults, then 3 en_1hz pulses -> sec_bcd 8'h03, min/hour 00, no ticks.
- INIT = 00:00:59, one en_1hz -> sec 00, min 01, tick_min high for one cycle, tick_hour 0.
- INIT = 23:59:59, one en_1hz -> 00:00:00; tick_min, tick_hour and tick_day all pulse in the same cycle.
- set_mode=1 at 10:59:30: inc_min -> 10:00:30; inc_hour x14 -> 00:00:30; en_1hz pulses leave sec at 30; no ticks.
- Run mode at 12:34:59: clr_sec coincident with en_1hz -> 12:34:00, no tick_min. Then assert rst mid-count -> outputs show INIT immediately, without waiting for a clock edge.
- WATCH_ALARM_EN, alarm 07:30, armed, time 07:29:59, en_1hz -> alarm_ring=1; after 60 further en_1hz -> 0. Repeat and deassert alarm_arm after 5 s -> alarm_ring 0 next edge.
